// File: rtl/branch_predictor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | branch_predictor                                                         |
// | Direct-mapped BTB with 2-bit saturating counters, misprediction flagging |
// | and saturating resolved-branch / misprediction statistics.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module branch_predictor #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCF,
  output logic        Predict_branchF,
  output logic [31:0] PredTargetF,
  input  logic        Eval_branch,
  input  logic [31:0] PCE,
  input  logic [31:0] PCPlus4E,
  input  logic [31:0] PCTargetE,
  input  logic        BranchTakenE,
  input  logic        Predict_branchE,
  output logic        MispredictE,
  output logic [31:0] RecoverPCE,
  output logic [31:0] BranchCount,
  output logic [31:0] MispredCount
);

  localparam int ENTRIES  = 2 ** INDEX_BITS;
  localparam int TAG_BITS = 32 - INDEX_BITS - 2;

  logic                valid_q  [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];

  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  logic [INDEX_BITS-1:0] f_idx, e_idx;
  logic [TAG_BITS-1:0]   f_tag, e_tag;
  logic                  f_hit, e_hit;

  // Word-aligned PCs: the low two bits never select anything.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

  assign f_idx = PCF[INDEX_BITS+1:2];
  assign f_tag = PCF[31:INDEX_BITS+2];
  assign e_idx = PCE[INDEX_BITS+1:2];
  assign e_tag = PCE[31:INDEX_BITS+2];

  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

  assign Predict_branchF = !rst && f_hit && ctr_q[f_idx][1];
  assign PredTargetF     = Predict_branchF ? target_q[f_idx] : 32'd0;

  assign MispredictE = !rst && Eval_branch && (Predict_branchE != BranchTakenE);
  assign RecoverPCE  = BranchTakenE ? PCTargetE : PCPlus4E;

  assign BranchCount  = branch_cnt_q;
  assign MispredCount = mispred_cnt_q;

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (Eval_branch && (branch_cnt_q != 32'hFFFF_FFFF))
      branch_cnt_d = branch_cnt_q + 32'd1;
    if (MispredictE && (mispred_cnt_q != 32'hFFFF_FFFF))
      mispred_cnt_d = mispred_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
      branch_cnt_q  <= 32'd0;
      mispred_cnt_q <= 32'd0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
      if (Eval_branch) begin
        if (e_hit) begin
          if (BranchTakenE) begin
            if (ctr_q[e_idx] != 2'b11) ctr_q[e_idx] <= ctr_q[e_idx] + 2'd1;
          end else begin
            if (ctr_q[e_idx] != 2'b00) ctr_q[e_idx] <= ctr_q[e_idx] - 2'd1;
          end
        end else if (BranchTakenE) begin
          valid_q[e_idx] <= 1'b1;
          ctr_q[e_idx]   <= 2'b10;
        end
      end
    end
  end

  // Tag and target carry no reset; they are only meaningful behind valid.
  always_ff @(posedge clk) begin
    if (!rst && Eval_branch && BranchTakenE) begin
      target_q[e_idx] <= PCTargetE;
      if (!e_hit) tag_q[e_idx] <= e_tag;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_branch_predictor                                                      |
// | Directed vector table plus randomized run against an array-based model.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCF;
  logic        Predict_branchF;
  logic [31:0] PredTargetF;
  logic        Eval_branch;
  logic [31:0] PCE, PCPlus4E, PCTargetE;
  logic        BranchTakenE, Predict_branchE;
  logic        MispredictE;
  logic [31:0] RecoverPCE, BranchCount, MispredCount;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_predictor #(.INDEX_BITS(6)) dut (
    .clk(clk), .rst(rst), .PCF(PCF),
    .Predict_branchF(Predict_branchF), .PredTargetF(PredTargetF),
    .Eval_branch(Eval_branch), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .PCTargetE(PCTargetE), .BranchTakenE(BranchTakenE),
    .Predict_branchE(Predict_branchE), .MispredictE(MispredictE),
    .RecoverPCE(RecoverPCE), .BranchCount(BranchCount),
    .MispredCount(MispredCount)
  );

  typedef struct {
    logic        rst;
    logic        ev;
    logic [31:0] pce, pcp4, pct;
    logic        bt, pbe;
    logic [31:0] pcf;
    logic        e_pf;
    logic [31:0] e_pt;
    logic        e_mis;
    logic [31:0] e_rec, e_bc, e_mc;
  } vec_t;

  vec_t vecs[17];

  // Reference model: plain per-entry state, counter held as an integer 0..3.
  bit          m_valid [64];
  int unsigned m_tag   [64];
  int unsigned m_tgt   [64];
  int          m_ctr   [64];
  int unsigned m_bc, m_mc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic ev, input logic [31:0] pce,
                       input logic [31:0] pcp4, input logic [31:0] pct,
                       input logic bt, input logic pbe, input logic [31:0] pcf);
    rst = r; Eval_branch = ev; PCE = pce; PCPlus4E = pcp4; PCTargetE = pct;
    BranchTakenE = bt; Predict_branchE = pbe; PCF = pcf;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_bc = 0;
    m_mc = 0;
  endtask

  function automatic vec_t mk(logic r, logic ev, logic [31:0] pce, logic [31:0] pcp4,
                              logic [31:0] pct, logic bt, logic pbe, logic [31:0] pcf,
                              logic pf, logic [31:0] pt, logic mis, logic [31:0] rec,
                              logic [31:0] bc, logic [31:0] mc);
    vec_t v;
    v.rst = r; v.ev = ev; v.pce = pce; v.pcp4 = pcp4; v.pct = pct; v.bt = bt;
    v.pbe = pbe; v.pcf = pcf; v.e_pf = pf; v.e_pt = pt; v.e_mis = mis;
    v.e_rec = rec; v.e_bc = bc; v.e_mc = mc;
    return v;
  endfunction

  initial begin
    //            rst ev pce     pcp4    pct     bt pbe pcf       pf pt      mis rec     bc mc
    vecs[0]  = mk(0, 0, 32'h0,   32'h0,  32'h0,  0, 0, 32'h40,  0, 32'h0,   0, 32'h0,   0, 0);
    vecs[1]  = mk(0, 1, 32'h40,  32'h44, 32'h100,1, 0, 32'h40,  0, 32'h0,   1, 32'h100, 1, 1);
    vecs[2]  = mk(0, 0, 32'h40,  32'h44, 32'h100,0, 0, 32'h40,  1, 32'h100, 0, 32'h44,  1, 1);
    vecs[3]  = mk(0, 1, 32'h40,  32'h44, 32'h100,1, 1, 32'h40,  1, 32'h100, 0, 32'h100, 2, 1);
    vecs[4]  = mk(0, 1, 32'h40,  32'h44, 32'h100,0, 1, 32'h40,  1, 32'h100, 1, 32'h44,  3, 2);
    vecs[5]  = mk(0, 1, 32'h40,  32'h44, 32'h100,0, 1, 32'h40,  1, 32'h100, 1, 32'h44,  4, 3);
    vecs[6]  = mk(0, 0, 32'h40,  32'h44, 32'h100,0, 0, 32'h40,  0, 32'h0,   0, 32'h44,  4, 3);
    vecs[7]  = mk(0, 1, 32'h40,  32'h44, 32'h100,1, 0, 32'h40,  0, 32'h0,   1, 32'h100, 5, 4);
    vecs[8]  = mk(0, 0, 32'h140, 32'h144,32'h200,0, 0, 32'h140, 0, 32'h0,   0, 32'h144, 5, 4);
    vecs[9]  = mk(0, 1, 32'h140, 32'h144,32'h200,1, 0, 32'h40,  1, 32'h100, 1, 32'h200, 6, 5);
    vecs[10] = mk(0, 0, 32'h0,   32'h0,  32'h0,  0, 0, 32'h140, 1, 32'h200, 0, 32'h0,   6, 5);
    vecs[11] = mk(0, 0, 32'h0,   32'h0,  32'h0,  0, 0, 32'h40,  0, 32'h0,   0, 32'h0,   6, 5);
    vecs[12] = mk(0, 0, 32'h0,   32'h44, 32'h0,  0, 1, 32'h140, 1, 32'h200, 0, 32'h44,  6, 5);
    vecs[13] = mk(0, 1, 32'h500, 32'h504,32'h0,  0, 1, 32'h140, 1, 32'h200, 1, 32'h504, 7, 6);
    vecs[14] = mk(1, 1, 32'h140, 32'h144,32'h300,1, 0, 32'h140, 0, 32'h0,   0, 32'h300, 0, 0);
    vecs[15] = mk(0, 0, 32'h0,   32'h0,  32'h0,  0, 0, 32'h140, 0, 32'h0,   0, 32'h0,   0, 0);
    vecs[16] = mk(0, 0, 32'h0,   32'h0,  32'h0,  0, 0, 32'h40,  0, 32'h0,   0, 32'h0,   0, 0);

    drive(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ev, vecs[i].pce, vecs[i].pcp4, vecs[i].pct,
            vecs[i].bt, vecs[i].pbe, vecs[i].pcf);
      #2;
      chk($sformatf("v%0d Predict_branchF", i), {31'd0, Predict_branchF}, {31'd0, vecs[i].e_pf});
      chk($sformatf("v%0d PredTargetF", i), PredTargetF, vecs[i].e_pt);
      chk($sformatf("v%0d MispredictE", i), {31'd0, MispredictE}, {31'd0, vecs[i].e_mis});
      chk($sformatf("v%0d RecoverPCE", i), RecoverPCE, vecs[i].e_rec);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d BranchCount", i), BranchCount, vecs[i].e_bc);
      chk($sformatf("v%0d MispredCount", i), MispredCount, vecs[i].e_mc);
    end

    // Randomized phase: resynchronise model and DUT with a reset first.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    model_reset();

    for (int n = 0; n < 400; n++) begin
      logic        r, ev, bt, pbe, e_pf, e_mis;
      logic [31:0] pce, pcf, pct, pcp4, e_pt;
      int unsigned fi, ft, ei, et;
      bit          fhit, ehit;

      r    = ($urandom_range(0, 49) == 0);
      ev   = ($urandom_range(0, 9) < 7);
      bt   = $urandom_range(0, 1);
      pbe  = $urandom_range(0, 1);
      pce  = ($urandom_range(0, 7) << 8) | ($urandom_range(0, 3) << 2);
      pcf  = ($urandom_range(0, 7) << 8) | ($urandom_range(0, 3) << 2);
      pct  = $urandom & 32'hFFFF_FFFC;
      pcp4 = pce + 32'd4;
      drive(r, ev, pce, pcp4, pct, bt, pbe, pcf);
      #2;

      fi = (pcf >> 2) % 64;  ft = pcf >> 8;
      ei = (pce >> 2) % 64;  et = pce >> 8;
      fhit  = m_valid[fi] && (m_tag[fi] == ft);
      ehit  = m_valid[ei] && (m_tag[ei] == et);
      e_pf  = !r && fhit && (m_ctr[fi] >= 2);
      e_pt  = e_pf ? m_tgt[fi] : 32'd0;
      e_mis = !r && ev && (pbe != bt);

      chk("rand Predict_branchF", {31'd0, Predict_branchF}, {31'd0, e_pf});
      chk("rand PredTargetF", PredTargetF, e_pt);
      chk("rand MispredictE", {31'd0, MispredictE}, {31'd0, e_mis});
      chk("rand RecoverPCE", RecoverPCE, bt ? pct : pcp4);

      @(posedge clk);
      #1;
      if (r) begin
        model_reset();
      end else if (ev) begin
        if (m_bc != 32'hFFFF_FFFF) m_bc++;
        if (e_mis && m_mc != 32'hFFFF_FFFF) m_mc++;
        if (ehit) begin
          if (bt) begin
            m_ctr[ei] = (m_ctr[ei] < 3) ? m_ctr[ei] + 1 : 3;
            m_tgt[ei] = pct;
          end else begin
            m_ctr[ei] = (m_ctr[ei] > 0) ? m_ctr[ei] - 1 : 0;
          end
        end else if (bt) begin
          m_valid[ei] = 1'b1;
          m_tag[ei]   = et;
          m_tgt[ei]   = pct;
          m_ctr[ei]   = 2;
        end
      end
      chk("rand BranchCount", BranchCount, m_bc);
      chk("rand MispredCount", MispredCount, m_mc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
# branch_predictor

Fetch-side dynamic branch predictor: a direct-mapped branch target buffer with a 2-bit saturating counter per entry.
- Sits upstream of the fetch stage. Each cycle it looks up the current fetch PC and supplies the taken prediction and predicted target that fetch registers into decode.
- Execute feeds each resolved branch back to train the table.
- The block also flags mispredictions and supplies the recovery PC.

## Interface
Parameters:
- INDEX_BITS, 6, log2 of entry count (64 entries); index = PC[INDEX_BITS+1:2], tag = PC[31:INDEX_BITS+2]

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- PCF  input  32  fetch PC to look up
- Predict_branchF  output  1  predicted taken for PCF
- PredTargetF  output  32  predicted target for PCF; 0 when Predict_branchF=0
- Eval_branch  input  1  a branch resolved in execute this cycle; update strobe
- PCE  input  32  PC of the resolving branch
- PCPlus4E  input  32  fall-through address of the resolving branch
- PCTargetE  input  32  computed target of the resolving branch
- BranchTakenE  input  1  actual outcome of the resolving branch
- Predict_branchE  input  1  prediction that was made for this branch (carried down the pipe)
- MispredictE  output  1  prediction did not match the outcome
- RecoverPCE  output  32  correct next PC for this branch
- BranchCount  output  32  number of branches resolved since reset
- MispredCount  output  32  number of mispredictions since reset

## Operation
Each entry holds: valid (1), tag (32-INDEX_BITS-2), target (32), ctr (2).

Lookup (combinational from PCF and current state):
- hit = valid[idx] && tag[idx] == PCF tag
- Predict_branchF = hit && ctr[idx][1]
- PredTargetF = Predict_branchF ? target[idx] : 0

Update (registered, when Eval_branch=1). idx and tag are taken from PCE:
- Entry hits and BranchTakenE=1:
  - ctr saturating increment (max 11)
  - target ← PCTargetE
- Entry hits and BranchTakenE=0:
  - ctr saturating decrement (min 00)
  - valid stays 1
- Entry misses and BranchTakenE=1: allocate, overwriting any aliased entry:
  - valid ← 1
  - tag ← PCE tag
  - target ← PCTargetE
  - ctr ← 10 (weakly taken)
- Entry misses and BranchTakenE=0: no table change.

Resolution (combinational, qualified by Eval_branch):
- MispredictE = Eval_branch && (Predict_branchE != BranchTakenE)
- RecoverPCE = BranchTakenE ? PCTargetE : PCPlus4E (driven regardless of Eval_branch)

Statistics:
- BranchCount increments on each Eval_branch.
- MispredCount increments on each MispredictE.
- Both saturate at 0xFFFFFFFF; they do not wrap.

## Timing
- Reset (rst high at a clock edge):
  - all valid ← 0, all ctr ← 01, BranchCount ← 0, MispredCount ← 0
  - tag and target contents are don't-care
- While rst is high, Predict_branchF, PredTargetF and MispredictE are forced to 0.
- Reset takes priority over a simultaneous Eval_branch; that update is dropped.
- Lookup latency is 0 cycles (combinational).
- An update written at edge N is visible to lookups from edge N onward.
- Same-cycle lookup and update of the same index: the lookup returns pre-update state; there is no write-to-read bypass.
- At most one update per cycle; Eval_branch is a single-cycle strobe per branch.
- Stalls have no effect on the block. Fetch is responsible for holding PCF. The block does not gate updates on stall, so execute must assert Eval_branch only for valid, non-flushed branches.
- Counter saturation:
  - ctr 11 + taken stays 11
  - ctr 00 + not-taken stays 00
  - stat counters hold at all-ones

## Test plan
- Reset, then PCF=0x40 → Predict_branchF=0, PredTargetF=0, BranchCount=0, MispredCount=0.
- Allocate: Eval_branch=1, PCE=0x40, BranchTakenE=1, PCTargetE=0x100, Predict_branchE=0 → MispredictE=1, RecoverPCE=0x100. Next cycle PCF=0x40 → Predict_branchF=1, PredTargetF=0x100; BranchCount=1, MispredCount=1.
- Hysteresis: starting from the allocated entry (ctr 10), resolve PCE=0x40 as taken, not-taken, not-taken (ctr 11, 10, 01) → lookup predicts 1 after the first and second updates and 0 after the third.
- Aliasing, INDEX_BITS=6: with 0x40 allocated, PCF=0x140 (same index 16, different tag) → Predict_branchF=0. A taken resolve at 0x140 with target 0x200 → 0x140 predicts 0x200 and 0x40 now predicts 0.
- Not-taken mispredict: Predict_branchE=1, BranchTakenE=0, PCPlus4E=0x44, Eval_branch=1 → MispredictE=1, RecoverPCE=0x44. With Eval_branch=0 under the same inputs → MispredictE=0 and no counter change.
- Reset mid-operation: assert rst with Eval_branch=1 on a taken branch at 0x40 → after the edge, PCF=0x40 predicts 0 and both stat counters read 0. A same-cycle read/write at one index returns the old value.
